sram_bus_arbiter: RTL and testbench
===================================

// Module: sram_bus_arbiter
// PURPOSE
//   Shares the single-port instruction/data SRAM between the instruction-fetch port (driven by the PC) and the MEM-stage load/store port.
//   Sequences each multi-cycle SRAM access and acknowledges the winning requester.
//   Drives a pipeline stall vector so the PC holds while fetch is blocked or waiting.
//   Sits between pc_reg/IF, MEM and the external SRAM pins.
// PARAMETERS
//   ADDR_W       32  byte-address width of both requester ports
//   DATA_W       32  data word width
//   WAIT_CYCLES  2   SRAM cycles per access; legal range >=1
// PORTS
//   clk           in   1         system clock; all logic on posedge
//   rst           in   1         synchronous, active-high reset
//   if_req_i      in   1         fetch request; held high until if_ack_o
//   if_addr_i     in   ADDR_W    fetch byte address (bits [1:0] ignored)
//   if_data_o     out  DATA_W    fetched word; valid while if_ack_o=1
//   if_ack_o      out  1         one-cycle fetch completion pulse
//   mem_req_i     in   1         load/store request; held high until mem_ack_o
//   mem_we_i      in   1         1=store, 0=load
//   mem_sel_i     in   4         byte enables for store
//   mem_addr_i    in   ADDR_W    data byte address (bits [1:0] ignored)
//   mem_wdata_i   in   DATA_W    store data
//   mem_rdata_o   out  DATA_W    load data; valid while mem_ack_o=1
//   mem_ack_o     out  1         one-cycle load/store completion pulse
//   sram_ce_o     out  1         SRAM chip enable, active high
//   sram_we_o     out  1         SRAM write enable, active high
//   sram_sel_o    out  4         SRAM byte enables
//   sram_addr_o   out  ADDR_W-2  SRAM word address = addr[ADDR_W-1:2]
//   sram_wdata_o  out  DATA_W    SRAM write data
//   sram_rdata_i  in   DATA_W    SRAM read data, valid in the last access cycle
//   stall_o       out  6         [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB; 1=hold
// BEHAVIOUR
//   - Reset (rst=1 at posedge): state=IDLE, wait counter=0; all registered outputs=0.
//   - Reset mid-access aborts the access; sram_ce_o/sram_we_o are 0 from the next cycle.
//     A partial store is tolerated and no ack is issued.
//   - FSM states IDLE, ACC_IF, ACC_MEM, RESP:
//     IDLE:    mem_req_i=1 -> ACC_MEM; else if_req_i=1 -> ACC_IF; else stay IDLE.
//              MEM has fixed priority on simultaneous requests because it is the older instruction.
//     ACC_*:   request fields are latched on entry; sram_ce_o=1 for exactly WAIT_CYCLES cycles.
//              sram_we_o/sel/wdata come from mem_* for ACC_MEM; for ACC_IF, we=0 and sel=4'hF.
//              The down-counter loads WAIT_CYCLES-1 on entry.
//              At count 0, sram_rdata_i is registered into the grantee's data output -> RESP.
//     RESP:    grantee ack=1 for one cycle; sram_ce_o=0; state returns to IDLE (no grant in RESP).
//   - Latency: request seen in IDLE at edge N; access cycles N+1..N+WAIT_CYCLES; ack in cycle N+WAIT_CYCLES+1.
//   - Back-to-back requests cost WAIT_CYCLES+2 cycles each.
//   - Requests deasserted before ack are a protocol violation (undefined; the bench asserts on it).
//   - Requests arriving during ACC or RESP wait; they are never dropped.
//   - Store data is not returned: mem_rdata_o is held at its previous value on store acks.
//   - if_data_o and mem_rdata_o hold their last value between acks.
//   - stall_o is combinational from state and requests:
//     mem_req_i=1 and mem_ack_o=0 -> 6'b011111 (hold PC..MEM, let WB drain);
//     else if_req_i=1 and if_ack_o=0 -> 6'b000011; else 6'b000000.
//   - The ack cycle itself releases the stall, so PC advances on the edge ending the ack cycle.
// TESTING
//   - Reset: rst=1 for 2 cycles with both reqs high -> acks=0, ce=0, stall_o=0 during reset.
//     First access starts on the cycle after rst falls.
//   - Lone fetch, WAIT_CYCLES=2, if_addr_i=0x0000_0010 -> sram_addr_o=0x4, ce=1 for 2 cycles.
//     if_ack_o=1 in cycle 3 with the SRAM word; stall_o=6'b000011 until ack.
//   - Simultaneous if_req/mem_req (load, addr 0x20) -> MEM served first (mem_ack at cycle 3).
//     IF is served next (if_ack at cycle 7); stall_o=6'b011111 until mem_ack.
//   - Store: mem_we_i=1, sel=4'b0011, wdata=0xDEADBEEF, addr 0x40 -> sram_we_o=1, sel=0011, addr=0x10 for WAIT_CYCLES cycles.
//     Then mem_ack pulses and mem_rdata_o is unchanged.
//   - Reset asserted in the second access cycle of a store -> ce/we=0 the next cycle.
//     No ack is issued; state=IDLE.
//   - WAIT_CYCLES=1 with 10 back-to-back fetches -> one ack every 3 cycles with no missed or duplicated acks.

Source files
------------

// File: rtl/sram_bus_arbiter.sv
// Arbitrates the shared single-port SRAM between instruction fetch and the MEM stage.
// MEM wins simultaneous requests; each access holds chip-enable for WAIT_CYCLES cycles, then acks.
module sram_bus_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ack_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_ack_o,
    output logic              sram_ce_o,
    output logic              sram_we_o,
    output logic [3:0]        sram_sel_o,
    output logic [ADDR_W-3:0] sram_addr_o,
    output logic [DATA_W-1:0] sram_wdata_o,
    input  logic [DATA_W-1:0] sram_rdata_i,
    output logic [5:0]        stall_o
);

    localparam int unsigned CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StAccIf, StAccMem, StResp} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              ce_q, ce_d;
    logic              we_q, we_d;
    logic [3:0]        sel_q, sel_d;
    logic [ADDR_W-3:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_data_q, if_data_d;
    logic              if_ack_q, if_ack_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              mem_ack_q, mem_ack_d;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr_i[1:0], mem_addr_i[1:0]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ce_d        = ce_q;
        we_d        = we_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mem_req_i) begin
                    state_d = StAccMem;
                    cnt_d   = CntLoad;
                    ce_d    = 1'b1;
                    we_d    = mem_we_i;
                    sel_d   = mem_sel_i;
                    addr_d  = mem_addr_i[ADDR_W-1:2];
                    wdata_d = mem_wdata_i;
                end else if (if_req_i) begin
                    state_d = StAccIf;
                    cnt_d   = CntLoad;
                    ce_d    = 1'b1;
                    we_d    = 1'b0;
                    sel_d   = 4'hF;
                    addr_d  = if_addr_i[ADDR_W-1:2];
                end
            end
            StAccIf, StAccMem: begin
                if (cnt_q == '0) begin
                    state_d = StResp;
                    ce_d    = 1'b0;
                    we_d    = 1'b0;
                    if (state_q == StAccIf) begin
                        if_data_d = sram_rdata_i;
                        if_ack_d  = 1'b1;
                    end else begin
                        mem_ack_d = 1'b1;
                        // Store acks leave the load-data register untouched.
                        if (!we_q) begin
                            mem_rdata_d = sram_rdata_i;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            ce_q        <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_data_q   <= '0;
            if_ack_q    <= 1'b0;
            mem_rdata_q <= '0;
            mem_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ce_q        <= ce_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_data_q   <= if_data_d;
            if_ack_q    <= if_ack_d;
            mem_rdata_q <= mem_rdata_d;
            mem_ack_q   <= mem_ack_d;
        end
    end

    // Stall is released during reset so the pipeline is not frozen by stale requests.
    always_comb begin
        stall_o = 6'b000000;
        if (!rst) begin
            if (mem_req_i && !mem_ack_q) begin
                stall_o = 6'b011111;
            end else if (if_req_i && !if_ack_q) begin
                stall_o = 6'b000011;
            end
        end
    end

    assign sram_ce_o    = ce_q;
    assign sram_we_o    = we_q;
    assign sram_sel_o   = sel_q;
    assign sram_addr_o  = addr_q;
    assign sram_wdata_o = wdata_q;
    assign if_data_o    = if_data_q;
    assign if_ack_o     = if_ack_q;
    assign mem_rdata_o  = mem_rdata_q;
    assign mem_ack_o    = mem_ack_q;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Scoreboard bench for sram_bus_arbiter: transaction-level timing model plus per-port expected queues.
module tb_sram_bus_arbiter;

    localparam int unsigned W = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, if_req, if_ack, mem_req, mem_we, mem_ack, sram_ce, sram_we;
    logic [31:0] if_addr, if_data, mem_addr, mem_wdata, mem_rdata, sram_wdata, sram_rdata;
    logic [3:0]  mem_sel, sram_sel;
    logic [29:0] sram_addr;
    logic [5:0]  stall;

    sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_data_o(if_data), .if_ack_o(if_ack),
        .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_sel_i(mem_sel), .mem_addr_i(mem_addr),
        .mem_wdata_i(mem_wdata), .mem_rdata_o(mem_rdata), .mem_ack_o(mem_ack),
        .sram_ce_o(sram_ce), .sram_we_o(sram_we), .sram_sel_o(sram_sel),
        .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata),
        .stall_o(stall)
    );

    // Second instance with a single wait cycle, fetch port only.
    logic        b_rst, b_if_req, b_if_ack, b_ce, b_zero;
    logic [31:0] b_if_addr, b_if_data, b_rdata, b_zero_word, b_rdata_unused, b_wdata_unused;
    logic        b_mem_ack_unused, b_we_unused;
    logic [3:0]  b_sel_unused;
    logic [29:0] b_addr;
    logic [5:0]  b_stall_unused;

    sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) dut_w1 (
        .clk(clk), .rst(b_rst),
        .if_req_i(b_if_req), .if_addr_i(b_if_addr), .if_data_o(b_if_data), .if_ack_o(b_if_ack),
        .mem_req_i(b_zero), .mem_we_i(b_zero), .mem_sel_i(4'h0), .mem_addr_i(b_zero_word),
        .mem_wdata_i(b_zero_word), .mem_rdata_o(b_rdata_unused), .mem_ack_o(b_mem_ack_unused),
        .sram_ce_o(b_ce), .sram_we_o(b_we_unused), .sram_sel_o(b_sel_unused),
        .sram_addr_o(b_addr), .sram_wdata_o(b_wdata_unused), .sram_rdata_i(b_rdata),
        .stall_o(b_stall_unused)
    );

    function automatic logic [31:0] init_word(input logic [31:0] w);
        return (w * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Bench-side SRAM: unwritten words read as init_word.
    logic [31:0] sram_arr [0:1023];
    logic        wr_valid [0:1023];
    logic [31:0] cur_word;
    assign cur_word   = wr_valid[sram_addr[9:0]] === 1'b1 ? sram_arr[sram_addr[9:0]]
                                                         : init_word({22'd0, sram_addr[9:0]});
    assign sram_rdata = (sram_ce && !sram_we) ? cur_word : 32'h0;
    always @(posedge clk) begin
        if (sram_ce && sram_we) begin
            sram_arr[sram_addr[9:0]] <= merge(cur_word, sram_wdata, sram_sel);
            wr_valid[sram_addr[9:0]] <= 1'b1;
        end
    end
    assign b_rdata = b_ce ? init_word({22'd0, b_addr[9:0]}) : 32'h0;

    typedef struct packed {logic is_store; logic [31:0] data;} mem_exp_t;
    logic [31:0] if_q [$];
    mem_exp_t    mem_q [$];
    logic [31:0] ref_mem [0:1023];
    int          n_checks = 0, n_err = 0, cyc = 0;
    bit          if_busy = 0, mem_busy = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s cyc=%0d got=none want=event", name, cyc);
    endtask

    task automatic issue_if(input logic [31:0] a);
        if_addr = a;
        if_req  = 1'b1;
        if_busy = 1'b1;
        if_q.push_back(ref_mem[a[11:2]]);
    endtask

    task automatic issue_mem(input logic we, input logic [3:0] sel, input logic [31:0] a,
                             input logic [31:0] wd);
        mem_exp_t e;
        mem_we = we; mem_sel = sel; mem_addr = a; mem_wdata = wd;
        mem_req  = 1'b1;
        mem_busy = 1'b1;
        e.is_store = we;
        if (we) ref_mem[a[11:2]] = merge(ref_mem[a[11:2]], wd, sel);
        e.data = ref_mem[a[11:2]];
        mem_q.push_back(e);
    endtask

    task automatic tick(input bit rnd);
        logic a_if, a_mem;
        @(negedge clk);
        a_if  = if_ack;
        a_mem = mem_ack;
        @(posedge clk);
        #1;
        if (if_busy && a_if) begin if_busy = 1'b0; if_req = 1'b0; end
        if (mem_busy && a_mem) begin mem_busy = 1'b0; mem_req = 1'b0; end
        if (rnd) begin
            if (!if_busy && $urandom_range(0, 2) == 0)
                issue_if(32'h400 + ($urandom_range(0, 255) << 2) + $urandom_range(0, 3));
            if (!mem_busy && $urandom_range(0, 2) == 0)
                issue_mem(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          32'h800 + ($urandom_range(0, 255) << 2) + $urandom_range(0, 3),
                          $urandom);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((if_busy || mem_busy) && n < 60) begin tick(1'b0); n++; end
        if (if_busy || mem_busy) fail("idle_timeout");
    endtask

    // Monitor: abstract bus model -- grant when free, MEM first, ack W+1 cycles after the grant.
    initial begin : monitor
        bit          g_valid, g_mem, g_we, e_ce, e_ia, e_ma;
        int          g_cyc, free_cyc;
        logic [29:0] g_addr;
        logic [3:0]  g_sel;
        logic [31:0] g_wdata, last_if, last_mem;
        logic [5:0]  e_stall;
        logic        p_if_req, p_if_ack, p_mem_req, p_mem_ack, p_rst;
        mem_exp_t    me;
        g_valid = 0; g_mem = 0; g_we = 0; g_cyc = 0; free_cyc = 0;
        g_addr = '0; g_sel = '0; g_wdata = '0; last_if = '0; last_mem = '0;
        p_if_req = 0; p_if_ack = 0; p_mem_req = 0; p_mem_ack = 0; p_rst = 1;
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                e_ce = g_valid && cyc > g_cyc && cyc <= g_cyc + int'(W);
                e_ia = g_valid && !g_mem && cyc == g_cyc + int'(W) + 1;
                e_ma = g_valid && g_mem && cyc == g_cyc + int'(W) + 1;
                chk("sram_ce", {31'd0, sram_ce}, {31'd0, e_ce});
                chk("sram_we", {31'd0, sram_we}, {31'd0, e_ce && g_we});
                if (e_ce) begin
                    chk("sram_addr", {2'd0, sram_addr}, {2'd0, g_addr});
                    chk("sram_sel", {28'd0, sram_sel}, {28'd0, g_sel});
                    if (g_we) chk("sram_wdata", sram_wdata, g_wdata);
                end
                chk("if_ack", {31'd0, if_ack}, {31'd0, e_ia});
                chk("mem_ack", {31'd0, mem_ack}, {31'd0, e_ma});
                if (e_ia) begin
                    if (if_q.size() == 0) fail("if_q_underflow");
                    else last_if = if_q.pop_front();
                end
                if (e_ma) begin
                    if (mem_q.size() == 0) fail("mem_q_underflow");
                    else begin
                        me = mem_q.pop_front();
                        if (!me.is_store) last_mem = me.data;
                    end
                end
                chk("if_data", if_data, last_if);
                chk("mem_rdata", mem_rdata, last_mem);
                e_stall = rst ? 6'b000000 : (mem_req && !e_ma) ? 6'b011111 :
                          (if_req && !e_ia) ? 6'b000011 : 6'b000000;
                chk("stall", {26'd0, stall}, {26'd0, e_stall});
                assert (rst || p_rst || !p_if_req || p_if_ack || if_req)
                    else $error("if_req dropped before if_ack");
                assert (rst || p_rst || !p_mem_req || p_mem_ack || mem_req)
                    else $error("mem_req dropped before mem_ack");
                p_if_req = if_req; p_if_ack = if_ack; p_mem_req = mem_req;
                p_mem_ack = mem_ack; p_rst = rst;
                if (rst) begin
                    g_valid = 0; free_cyc = cyc + 1; last_if = '0; last_mem = '0;
                end else begin
                    if (e_ia || e_ma) g_valid = 0;
                    if (!g_valid && cyc >= free_cyc && (mem_req || if_req)) begin
                        g_valid = 1; g_cyc = cyc; g_mem = mem_req;
                        g_addr  = mem_req ? mem_addr[31:2] : if_addr[31:2];
                        g_we    = mem_req && mem_we;
                        g_sel   = mem_req ? mem_sel : 4'hF;
                        g_wdata = mem_wdata;
                        free_cyc = cyc + int'(W) + 2;
                    end
                end
            end
        end
    end

    task automatic run_w1();
        int k = 0, last = 0, start;
        @(posedge clk);
        #1;
        b_rst = 1'b0; b_if_addr = 32'h100; b_if_req = 1'b1; start = cyc;
        while (k < 10 && cyc - start < 60) begin
            @(negedge clk);
            if (b_if_ack) begin
                chk("w1_fetch_data", b_if_data, init_word(32'h40 + 32'(k)));
                if (k > 0) chk("w1_ack_spacing", 32'(cyc - last), 32'd3);
                last = cyc;
                k++;
                @(posedge clk);
                #1;
                b_if_addr = b_if_addr + 32'd4;
                if (k == 10) b_if_req = 1'b0;
            end
        end
        chk("w1_ack_count", 32'(k), 32'd10);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(32'(i));
        rst = 1'b1; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
        mem_sel = '0; mem_addr = '0; mem_wdata = '0;
        b_rst = 1'b1; b_if_req = 1'b0; b_if_addr = '0; b_zero = 1'b0; b_zero_word = '0;
        // Both requests pending through reset; MEM must be served first afterwards.
        issue_if(32'h10);
        issue_mem(1'b0, 4'hF, 32'h20, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_idle();
        issue_if(32'h10);
        wait_idle();
        issue_mem(1'b1, 4'b0011, 32'h40, 32'hDEAD_BEEF);
        wait_idle();
        issue_mem(1'b0, 4'hF, 32'h40, 32'h0);
        wait_idle();
        // Reset during the second access cycle of a store.
        issue_mem(1'b1, 4'hF, 32'h44, 32'h1234_5678);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1; mem_req = 1'b0; mem_busy = 1'b0;
        mem_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) tick(1'b0);
        repeat (600) tick(1'b1);
        wait_idle();
        repeat (2) tick(1'b0);
        chk("if_q_drained", 32'(if_q.size()), 32'd0);
        chk("mem_q_drained", 32'(mem_q.size()), 32'd0);
        run_w1();
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule
